ctrl_decode_pipe: RTL and testbench

//  Second-generation control unit for the 5-stage RV32 pipeline.
//  - Decodes op/funct in D and drives ImmSrcD combinationally.
//  - Registers the remaining controls into an ID/EX control register with flush/hold.
//  - Flags illegal opcodes and, when EN_M=1, decodes M-extension ops.
//  - Stalls F/D while a multi-cycle mul/div occupies E.

---
 rtl/ctrl_pkg.sv | 56 +++++
 rtl/ctrl_decode_pipe_if.sv | 37 +++
 rtl/ctrl_decode_comb.sv | 75 +++++++
 rtl/ctrl_decode_pipe.sv | 100 ++++++++++
 tb/tb_ctrl_decode_pipe.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32 pipeline control unit: opcodes, control field codes,
// the multi-cycle FSM states and the E-stage control bundle.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] RES_UIMM = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DIV_BUSY = 2'd2
    } md_state_t;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic       lui;
        logic       md;
        logic [2:0] md_funct3;
        logic       illegal;
    } ctrl_t;

    function automatic int max_lat(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// D-stage decode inputs, hazard controls and E-stage control outputs of the control unit.
interface ctrl_decode_pipe_if;
    logic       instr_vld_d;
    logic [6:0] op_d;
    logic [2:0] funct3_d;
    logic [6:0] funct7_d;
    logic       stall_e;
    logic       flush_e;
    logic [2:0] ImmSrcD;
    logic       ValidE;
    logic       RegWriteE;
    logic       ALUSrcE;
    logic       MemWriteE;
    logic [1:0] ResultSrcE;
    logic [1:0] ALUOpE;
    logic       JumpE;
    logic       JalrE;
    logic       BranchE;
    logic       LuiE;
    logic       MdE;
    logic [2:0] MdFunct3E;
    logic       IllegalE;
    logic       md_done_e;
    logic       stall_fd;

    modport master (
        output instr_vld_d, op_d, funct3_d, funct7_d, stall_e, flush_e,
        input  ImmSrcD, ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, ALUOpE,
               JumpE, JalrE, BranchE, LuiE, MdE, MdFunct3E, IllegalE, md_done_e, stall_fd
    );

    modport slave (
        input  instr_vld_d, op_d, funct3_d, funct7_d, stall_e, flush_e,
        output ImmSrcD, ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, ALUOpE,
               JumpE, JalrE, BranchE, LuiE, MdE, MdFunct3E, IllegalE, md_done_e, stall_fd
    );
endinterface

// File: rtl/ctrl_decode_comb.sv
// Purely combinational opcode/funct decoder producing ImmSrc and the E-stage control bundle.
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] imm_src,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl    = '0;
        imm_src = IMM_I;
        case (op)
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
            end
            OP_STORE: begin
                imm_src        = IMM_S;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_R: begin
                // funct7=0000001 selects RV32M; without M support it is undecodable
                if (funct7 == F7_MULDIV) begin
                    if (EN_M) begin
                        ctrl.reg_write = 1'b1;
                        ctrl.md        = 1'b1;
                        ctrl.md_funct3 = funct3;
                    end else begin
                        ctrl.illegal = 1'b1;
                    end
                end else begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
            end
            OP_BRANCH: begin
                imm_src     = IMM_B;
                ctrl.alu_op = ALUOP_BR;
                ctrl.branch = 1'b1;
            end
            OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_JAL: begin
                imm_src         = IMM_J;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.jump       = 1'b1;
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.jalr       = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm_src         = IMM_U;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_UIMM;
                ctrl.lui        = op[5];
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// RV32 pipeline control unit: D-stage decode, ID/EX control register with flush/hold,
// and a busy FSM that freezes F/D while a multi-cycle mul/div occupies E.
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter bit EN_M    = 1'b1,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 34
) (
    input logic               clk,
    input logic               reset,
    ctrl_decode_pipe_if.slave bus
);

    localparam int MAX_LAT = max_lat(MUL_LAT, DIV_LAT);
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    logic [2:0]       imm_src;
    ctrl_t            dec_ctrl;
    ctrl_t            e_reg;
    logic             valid_reg;
    md_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             stall_fd;
    logic             hold;

    ctrl_decode_comb #(.EN_M(EN_M)) u_decode (
        .op      (bus.op_d),
        .funct3  (bus.funct3_d),
        .funct7  (bus.funct7_d),
        .imm_src (imm_src),
        .ctrl    (dec_ctrl)
    );

    assign stall_fd = (state_reg != ST_IDLE);
    assign hold     = bus.stall_e | stall_fd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            e_reg     <= '0;
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else if (bus.flush_e) begin
            valid_reg <= 1'b0;
            e_reg     <= '0;
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            if (!hold) begin
                valid_reg <= bus.instr_vld_d;
                e_reg     <= bus.instr_vld_d ? dec_ctrl : '0;
            end
            // The count runs regardless of stall_e so occupancy is exactly LAT cycles
            case (state_reg)
                ST_IDLE: begin
                    if (!hold && bus.instr_vld_d && dec_ctrl.md) begin
                        if (bus.funct3_d[2]) begin
                            cnt_reg   <= DIV_CNT;
                            state_reg <= (DIV_LAT > 1) ? ST_DIV_BUSY : ST_IDLE;
                        end else begin
                            cnt_reg   <= MUL_CNT;
                            state_reg <= (MUL_LAT > 1) ? ST_MUL_BUSY : ST_IDLE;
                        end
                    end
                end
                ST_MUL_BUSY, ST_DIV_BUSY: begin
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.ImmSrcD    = imm_src;
    assign bus.ValidE     = valid_reg;
    assign bus.RegWriteE  = e_reg.reg_write;
    assign bus.ALUSrcE    = e_reg.alu_src;
    assign bus.MemWriteE  = e_reg.mem_write;
    assign bus.ResultSrcE = e_reg.result_src;
    assign bus.ALUOpE     = e_reg.alu_op;
    assign bus.JumpE      = e_reg.jump;
    assign bus.JalrE      = e_reg.jalr;
    assign bus.BranchE    = e_reg.branch;
    assign bus.LuiE       = e_reg.lui;
    assign bus.MdE        = e_reg.md;
    assign bus.MdFunct3E  = e_reg.md_funct3;
    assign bus.IllegalE   = e_reg.illegal;
    assign bus.md_done_e  = valid_reg & e_reg.md & (state_reg == ST_IDLE);
    assign bus.stall_fd   = stall_fd;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: directed scenarios plus randomized traffic against a
// table-driven decode model and a remaining-stall-cycles occupancy model.
module tb_ctrl_decode_pipe;

    typedef struct packed {
        logic       rw;
        logic       alusrc;
        logic       mw;
        logic [1:0] rs;
        logic [1:0] aluop;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic       lui;
        logic       md;
        logic [2:0] mdf3;
        logic       illegal;
    } exp_t;

    localparam int MUL_L = 3;
    localparam int DIV_L = 34;

    logic clk;
    logic rst;
    logic       vld;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       st_e;
    logic       fl;

    int checks = 0;
    int errors = 0;

    // model state
    logic m_valid;
    exp_t m_e;
    int   m_left;

    ctrl_decode_pipe_if bus ();
    ctrl_decode_pipe_if bus_nm ();

    assign bus.instr_vld_d = vld;
    assign bus.op_d        = op;
    assign bus.funct3_d    = f3;
    assign bus.funct7_d    = f7;
    assign bus.stall_e     = st_e;
    assign bus.flush_e     = fl;
    assign bus_nm.instr_vld_d = vld;
    assign bus_nm.op_d        = op;
    assign bus_nm.funct3_d    = f3;
    assign bus_nm.funct7_d    = f7;
    assign bus_nm.stall_e     = st_e;
    assign bus_nm.flush_e     = fl;

    ctrl_decode_pipe #(.EN_M(1'b1), .MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    ctrl_decode_pipe #(.EN_M(1'b0), .MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut_nm (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_nm)
    );

    exp_t act_e;
    assign act_e = {bus.RegWriteE, bus.ALUSrcE, bus.MemWriteE, bus.ResultSrcE, bus.ALUOpE,
                    bus.JumpE, bus.JalrE, bus.BranchE, bus.LuiE, bus.MdE, bus.MdFunct3E,
                    bus.IllegalE};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_decode(input logic [6:0] o, input logic [2:0] a,
                                       input logic [6:0] b, input bit en_m,
                                       output logic [2:0] imm, output exp_t e);
        e   = '0;
        imm = 3'b000;
        case (o)
            7'b0000011: begin e.rw = 1; e.alusrc = 1; e.rs = 2'b01; end
            7'b0100011: begin imm = 3'b001; e.alusrc = 1; e.mw = 1; end
            7'b0110011: begin
                if (b == 7'b0000001) begin
                    if (en_m) begin e.rw = 1; e.md = 1; e.mdf3 = a; end
                    else e.illegal = 1;
                end else begin
                    e.rw = 1; e.aluop = 2'b10;
                end
            end
            7'b1100011: begin imm = 3'b010; e.aluop = 2'b01; e.branch = 1; end
            7'b0010011: begin e.rw = 1; e.alusrc = 1; e.aluop = 2'b10; end
            7'b1101111: begin imm = 3'b011; e.rw = 1; e.rs = 2'b10; e.jump = 1; end
            7'b1100111: begin e.rw = 1; e.alusrc = 1; e.rs = 2'b10; e.jalr = 1; end
            7'b0110111, 7'b0010111: begin imm = 3'b100; e.rw = 1; e.rs = 2'b11; e.lui = o[5]; end
            default: e.illegal = 1;
        endcase
    endfunction

    // Advance the model with the currently driven inputs, then clock once.
    task automatic cycle();
        logic [2:0] imm;
        exp_t d;
        int nl;
        ref_decode(op, f3, f7, 1'b1, imm, d);
        if (!rst || fl) begin
            m_valid = 0; m_e = '0; m_left = 0;
        end else begin
            nl = (m_left > 0) ? m_left - 1 : 0;
            if (!(st_e || m_left > 0)) begin
                m_valid = vld;
                m_e     = vld ? d : '0;
                if (vld && d.md) nl = (f3[2] ? DIV_L : MUL_L) - 1;
            end
            m_left = nl;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] a, input logic [6:0] b);
        vld = v; op = o; f3 = a; f7 = b;
    endtask

    task automatic test_reset();
        rst = 0; st_e = 0; fl = 0;
        drive(1, 7'b0000011, 3'b010, 7'b0);
        cycle();
        cycle();
        checks++;
        if (bus.ValidE !== 1'b0 || act_e !== exp_t'(0) || bus.stall_fd !== 1'b0 || bus.md_done_e !== 1'b0) begin
            errors++;
            $display("FAIL reset: ValidE=%b ctrl=%h stall_fd=%b done=%b required all 0",
                     bus.ValidE, act_e, bus.stall_fd, bus.md_done_e);
        end
        $display("reset: ValidE=%b ctrl=%h stall_fd=%b", bus.ValidE, act_e, bus.stall_fd);
        rst = 1;
    endtask

    task automatic test_lw();
        drive(1, 7'b0000011, 3'b010, 7'b0);
        #1;
        checks++;
        if (bus.ImmSrcD !== 3'b000) begin
            errors++; $display("FAIL lw_imm: ImmSrcD=%b required 000", bus.ImmSrcD);
        end
        cycle();
        checks++;
        if (bus.ValidE !== 1 || bus.RegWriteE !== 1 || bus.ResultSrcE !== 2'b01 || bus.ALUSrcE !== 1) begin
            errors++;
            $display("FAIL lw: ValidE=%b RegWriteE=%b ResultSrcE=%b ALUSrcE=%b required 1 1 01 1",
                     bus.ValidE, bus.RegWriteE, bus.ResultSrcE, bus.ALUSrcE);
        end
        $display("lw: ValidE=%b RegWriteE=%b ResultSrcE=%b", bus.ValidE, bus.RegWriteE, bus.ResultSrcE);
    endtask

    task automatic test_lui_auipc();
        logic [6:0] ops [2];
        ops[0] = 7'b0110111;
        ops[1] = 7'b0010111;
        for (int i = 0; i < 2; i++) begin
            drive(1, ops[i], 3'($urandom), 7'($urandom));
            #1;
            checks++;
            if (bus.ImmSrcD !== 3'b100) begin
                errors++; $display("FAIL u_imm%0d: ImmSrcD=%b required 100", i, bus.ImmSrcD);
            end
            cycle();
            checks++;
            if (bus.LuiE !== (i == 0) || bus.ResultSrcE !== 2'b11 || bus.ValidE !== 1) begin
                errors++;
                $display("FAIL u_type%0d: LuiE=%b ResultSrcE=%b required %0d 11", i, bus.LuiE, bus.ResultSrcE, (i == 0));
            end
            $display("u-type op=%b: LuiE=%b ResultSrcE=%b", ops[i], bus.LuiE, bus.ResultSrcE);
        end
    endtask

    task automatic test_illegal();
        exp_t ex;
        ex = '0;
        ex.illegal = 1;
        drive(1, 7'b1111111, 3'b000, 7'b0);
        cycle();
        checks++;
        if (bus.ValidE !== 1 || act_e !== ex) begin
            errors++; $display("FAIL illegal_op: ValidE=%b ctrl=%h required 1 %h", bus.ValidE, act_e, ex);
        end
        $display("illegal op: ValidE=%b ctrl=%h", bus.ValidE, act_e);
        drive(1, 7'b0110011, 3'b000, 7'b0000001);
        cycle();
        checks++;
        if (bus_nm.IllegalE !== 1 || bus_nm.MdE !== 0) begin
            errors++; $display("FAIL no_m_illegal: IllegalE=%b MdE=%b required 1 0", bus_nm.IllegalE, bus_nm.MdE);
        end
        checks++;
        if (bus.IllegalE !== 0 || bus.MdE !== 1) begin
            errors++; $display("FAIL m_legal: IllegalE=%b MdE=%b required 0 1", bus.IllegalE, bus.MdE);
        end
        $display("R f7=1: EN_M=0 IllegalE=%b, EN_M=1 MdE=%b", bus_nm.IllegalE, bus.MdE);
        drive(0, 7'b0, 3'b0, 7'b0);
        for (int k = 0; k < MUL_L; k++) cycle();
    endtask

    task automatic test_md(input logic [2:0] fn, input int lat);
        int n = 0;
        logic done_seen = 0;
        drive(1, 7'b0110011, fn, 7'b0000001);
        cycle();
        drive(0, 7'b0, 3'b0, 7'b0);
        for (int k = 0; k < lat; k++) begin
            if (bus.stall_fd === 1'b1) n++;
            if (k == lat - 1) done_seen = bus.md_done_e;
            else if (bus.md_done_e !== 1'b0) begin
                checks++; errors++;
                $display("FAIL md_early_done: cycle %0d md_done_e=%b required 0", k, bus.md_done_e);
            end
            cycle();
        end
        checks++;
        if (n != lat - 1 || done_seen !== 1'b1) begin
            errors++;
            $display("FAIL md_lat f3=%b: stall_fd cycles=%0d done=%b required %0d 1", fn, n, done_seen, lat - 1);
        end
        $display("md f3=%b: stall_fd cycles=%0d done=%b", fn, n, done_seen);
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        drive(1, 7'b0110011, 3'b001, 7'b0000001);
        cycle();
        for (int k = 0; k < 2 * MUL_L; k++) begin
            if (bus.stall_fd !== ((k % MUL_L) != MUL_L - 1) ||
                bus.md_done_e !== ((k % MUL_L) == MUL_L - 1)) bad++;
            if (k == MUL_L) drive(0, 7'b0, 3'b0, 7'b0);
            cycle();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL back_to_back: %0d bad cycles required 0", bad);
        end
        $display("back-to-back mul: bad cycles=%0d", bad);
    endtask

    task automatic test_stall_done();
        drive(1, 7'b0110011, 3'b000, 7'b0000001);
        cycle();
        drive(0, 7'b0, 3'b0, 7'b0);
        cycle();
        cycle();
        st_e = 1;
        cycle();
        cycle();
        checks++;
        if (bus.md_done_e !== 1 || bus.stall_fd !== 0 || bus.MdE !== 1) begin
            errors++;
            $display("FAIL stall_done: md_done_e=%b stall_fd=%b MdE=%b required 1 0 1", bus.md_done_e, bus.stall_fd, bus.MdE);
        end
        st_e = 0;
        cycle();
        checks++;
        if (bus.md_done_e !== 0 || bus.ValidE !== 0) begin
            errors++; $display("FAIL stall_done_release: md_done_e=%b ValidE=%b required 0 0", bus.md_done_e, bus.ValidE);
        end
        $display("stall on done: held then released");
    endtask

    task automatic test_abort(input bit use_reset);
        drive(1, 7'b0110011, 3'b100, 7'b0000001);
        cycle();
        drive(0, 7'b0, 3'b0, 7'b0);
        repeat (4) cycle();
        checks++;
        if (bus.stall_fd !== 1) begin
            errors++; $display("FAIL abort_busy: stall_fd=%b required 1", bus.stall_fd);
        end
        if (use_reset) rst = 0; else fl = 1;
        cycle();
        rst = 1; fl = 0;
        checks++;
        if (bus.ValidE !== 0 || bus.stall_fd !== 0 || bus.MdE !== 0) begin
            errors++;
            $display("FAIL abort rst=%0d: ValidE=%b stall_fd=%b MdE=%b required 0 0 0", use_reset, bus.ValidE, bus.stall_fd, bus.MdE);
        end
        $display("div abort via %s: ValidE=%b stall_fd=%b", use_reset ? "reset" : "flush", bus.ValidE, bus.stall_fd);
    endtask

    task automatic test_stall_jal();
        drive(1, 7'b1101111, 3'b0, 7'b0);
        cycle();
        checks++;
        if (bus.JumpE !== 1) begin
            errors++; $display("FAIL jal_load: JumpE=%b required 1", bus.JumpE);
        end
        st_e = 1;
        drive(1, 7'b0000011, 3'b0, 7'b0);
        cycle();
        cycle();
        checks++;
        if (bus.JumpE !== 1 || bus.ResultSrcE !== 2'b10) begin
            errors++; $display("FAIL jal_hold: JumpE=%b ResultSrcE=%b required 1 10", bus.JumpE, bus.ResultSrcE);
        end
        fl = 1;
        cycle();
        checks++;
        if (bus.ValidE !== 0 || bus.JumpE !== 0) begin
            errors++; $display("FAIL flush_over_stall: ValidE=%b JumpE=%b required 0 0", bus.ValidE, bus.JumpE);
        end
        fl = 0; st_e = 0;
        $display("jal stall/flush: JumpE=%b ValidE=%b", bus.JumpE, bus.ValidE);
    endtask

    task automatic test_random();
        logic [6:0] tbl [10];
        logic [2:0] imm;
        exp_t d;
        int idx;
        tbl = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        for (int t = 0; t < 400; t++) begin
            idx  = $urandom_range(0, 10);
            vld  = ($urandom_range(0, 3) != 0);
            op   = (idx == 10) ? 7'($urandom) : tbl[idx];
            f3   = 3'($urandom);
            f7   = ($urandom_range(0, 1) != 0) ? 7'b0000001 : 7'($urandom);
            st_e = ($urandom_range(0, 7) == 0);
            fl   = ($urandom_range(0, 31) == 0);
            rst  = ($urandom_range(0, 99) != 0);
            #1;
            ref_decode(op, f3, f7, 1'b1, imm, d);
            checks++;
            if (bus.ImmSrcD !== imm) begin
                errors++; $display("FAIL rnd_imm t=%0d: ImmSrcD=%b required %b", t, bus.ImmSrcD, imm);
            end
            cycle();
            checks++;
            if (bus.ValidE !== m_valid || act_e !== m_e || bus.stall_fd !== (m_left > 0) ||
                bus.md_done_e !== (m_valid && m_e.md && m_left == 0)) begin
                errors++;
                $display("FAIL rnd t=%0d: ValidE=%b ctrl=%h stall_fd=%b done=%b required %b %h %b %b",
                         t, bus.ValidE, act_e, bus.stall_fd, bus.md_done_e,
                         m_valid, m_e, (m_left > 0), (m_valid && m_e.md && m_left == 0));
            end
            $display("rnd t=%0d op=%b vld=%b st=%b fl=%b rst=%b -> ValidE=%b ctrl=%h stall_fd=%b",
                     t, op, vld, st_e, fl, rst, bus.ValidE, act_e, bus.stall_fd);
        end
        rst = 1; st_e = 0; fl = 0;
        drive(0, 7'b0, 3'b0, 7'b0);
    endtask

    initial begin
        m_valid = 0; m_e = '0; m_left = 0;
        rst = 0; st_e = 0; fl = 0;
        drive(0, 7'b0, 3'b0, 7'b0);
        #1;
        test_reset();
        test_lw();
        test_lui_auipc();
        test_illegal();
        test_md(3'b000, MUL_L);
        test_md(3'b100, DIV_L);
        test_back_to_back();
        test_stall_done();
        test_abort(1'b0);
        test_abort(1'b1);
        test_stall_jal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
